led_matrix_scan: RTL
====================

# led_matrix_scan

Time-multiplexed driver for the 4-column × 8-row LED matrix, sitting directly downstream of the SoC's LED and debug signals. It takes four 8-bit column bitmaps plus a 3-bit global brightness and drives the row and column pins of the board. Columns are scanned round-robin, each row is PWM-dimmed within its column slot, and one dark phase per slot suppresses ghosting. All outputs are registered.

## Interface
- `PRESCALE`, default 256: clk cycles per PWM phase tick; legal range ≥1.
- `clk`  in  1  system clock (12 MHz on board).
- `rst`  in  1  reset; asynchronous, active-high.
- `leds1`…`leds4`  in  8 each  row bitmap for columns 0…3; bit n=1 lights row n+1.
- `leds_pwm`  in  3  global brightness; 0 = off, 7 = maximum.
- `led1`…`led8`  out  1 each  row drives, active-low (0 = lit). Reset value: 1.
- `lcol1`…`lcol4`  out  1 each  column selects, active-low (0 = selected). Reset value: 1.
- `frame`  out  1  one-cycle pulse marking the start of column 0's slot. Reset value: 0.

## Operation
- State: prescale counter `pre` (0…PRESCALE-1), phase counter `ph` (0…PMAX), column index `col` (0…3), snapshot `snap[7:0]`, threshold `thr`.
- `tick` is asserted when `pre == PRESCALE-1`. `pre` wraps to 0 on tick. With PRESCALE=1, tick is asserted every cycle.
- On tick:
  - If `ph < PMAX`: `ph` increments.
  - Otherwise: `ph` goes to 0, `col` goes to `(col+1) mod 4`, `snap` loads the bitmap of the new column, and `thr` loads `f(leds_pwm)`.
- Inputs are sampled only at slot start. Changes to `leds*` or `leds_pwm` mid-slot take effect from the next slot.
- Non-gamma build: PMAX = 7 and `f(b) = b`. Duty per lit row is b/8.
- Phase PMAX is the blanking phase. All `lcol*` = 1 and all `led*` = 1 regardless of `snap`.
- Otherwise:
  - The selected column's `lcol` = 0 and the other columns = 1.
  - `led(n+1)` = 0 iff `snap[n]` = 1 and `ph < thr`.
- Reset state: `col` = 0, `ph` = 0, `pre` = 0, `snap` = 0, `thr` = 0. The first slot after reset is therefore dark, and live data first appears in column 1's slot.
- Reset asserted mid-scan forces all outputs inactive immediately (asynchronous), with no wait for a clock edge.

## Timing
- Outputs are registered from state. Pins reflect `col`/`ph`/`snap` one clk after those values change.
- Slot length = (PMAX+1) × PRESCALE cycles. Frame = 4 slots.
  - Default non-gamma: 2048 cycles/slot, about 1465 Hz frame rate.
  - Default gamma: 16384 cycles/slot, about 183 Hz frame rate.
- `frame` is high for exactly one clk: the first cycle on which `lcol1` reflects the new column-0 slot, i.e. one clk after `col` wraps 3→0.
- Column pins never overlap. Between any two different columns being selected there is at least PRESCALE cycles with all columns deselected.
- `pre` width is max(1, clog2(PRESCALE)). `ph` width is clog2(PMAX+1).

## Configuration
- `LED_GAMMA_EN` defined:
  - PMAX = 63 (6-bit phase).
  - `f` comes from the gamma table {0,1,2,5,10,18,32,62} indexed by `leds_pwm`.
  - Brightness 7 gives 62/64 duty.
- `LED_GAMMA_EN` undefined: linear 3-bit behaviour, PMAX = 7.
- All other behaviour (blanking phase, snapshot rules, `frame` pulse) is identical in both builds.

## Structure
- Package `led_scan_pkg` holds:
  - `NUM_COLS` = 4 and `NUM_ROWS` = 8.
  - The PMAX constants for both builds.
  - The 8-entry gamma table constant.
- Sub-module `led_scan_prescaler` contains the `pre` counter and emits `tick`.
- Phase, column, snapshot and output registers live in `led_matrix_scan`.

## Test plan
- **Reset:** hold `rst` high with `clk` running → all `led*` and `lcol*` = 1, `frame` = 0. Release reset → first slot (column 0) stays fully dark.
- **Scan order:** PRESCALE=2, `leds1`..`leds4` = 8'h01/8'h02/8'h04/8'h08, `leds_pwm` = 7, non-gamma build.
  - Columns select in order 1→2→3→4→1, each for 14 cycles followed by a 2-cycle all-dark gap.
  - `led1`..`led4` go low respectively during their column.
  - `frame` pulses every 64 cycles.
- **PWM duty:** PRESCALE=1, `leds2` = 8'hFF, `leds_pwm` = 3 → during column 1's slot all rows are low for exactly 3 of 8 cycles. With `leds_pwm` = 0 → no row is ever low.
- **Mid-slot change:** change `leds_pwm` 7→1 and `leds3` 8'hFF→8'h00 in the middle of column 2's slot → the current slot is unaffected, and the new values appear from the next slot.
- **Gamma build** (`LED_GAMMA_EN`), PRESCALE=1, `leds_pwm` = 4 → lit rows are low for 10 of 64 cycles per slot. Phase 63 is all-dark.
- **Reset mid-operation:** assert `rst` during a lit phase → outputs go to 1 with no clk edge. After release, scanning restarts at column 0 with that slot dark.

Source files
------------

// File: rtl/led_scan_pkg.sv
// Shared constants for the LED matrix scanner: matrix geometry, phase ranges
// for the linear and gamma builds, and the gamma brightness table.
package led_scan_pkg;

    localparam int unsigned NUM_COLS   = 4;
    localparam int unsigned NUM_ROWS   = 8;

    // Last phase index of a slot; that phase is always blanked.
    localparam int unsigned PMAX_LIN   = 7;
    localparam int unsigned PMAX_GAMMA = 63;

    // Gamma thresholds indexed by 3-bit brightness (entry 0 is rightmost).
    localparam logic [7:0][5:0] GAMMA_TBL = {
        6'd62, 6'd32, 6'd18, 6'd10, 6'd5, 6'd2, 6'd1, 6'd0
    };

    function automatic logic [5:0] gamma_lookup(input logic [2:0] b);
        return GAMMA_TBL[b];
    endfunction

endpackage

// File: rtl/led_scan_prescaler.sv
// Free-running divider: asserts tick once every PRESCALE clk cycles.
module led_scan_prescaler #(
    parameter int unsigned PRESCALE = 256
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PreW-1:0] pre_q, pre_d;

    assign tick = (pre_q == PreW'(PRESCALE - 1));

    // Count up, wrapping to zero on the tick cycle.
    always_comb begin
        pre_d = tick ? '0 : pre_q + PreW'(1);
    end

    // Prescale counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/led_matrix_scan.sv
// Time-multiplexed 4-column x 8-row LED matrix driver with per-slot PWM and a
// blanking phase at the end of every column slot. All pins are registered.
// Build option: define LED_GAMMA_EN for a 64-phase slot with gamma-mapped
// brightness; otherwise an 8-phase slot with linear brightness.
module led_matrix_scan
    import led_scan_pkg::*;
#(
    parameter int unsigned PRESCALE = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] leds1,
    input  logic [7:0] leds2,
    input  logic [7:0] leds3,
    input  logic [7:0] leds4,
    input  logic [2:0] leds_pwm,
    output logic       led1,
    output logic       led2,
    output logic       led3,
    output logic       led4,
    output logic       led5,
    output logic       led6,
    output logic       led7,
    output logic       led8,
    output logic       lcol1,
    output logic       lcol2,
    output logic       lcol3,
    output logic       lcol4,
    output logic       frame
);

`ifdef LED_GAMMA_EN
    localparam int unsigned PMAX = PMAX_GAMMA;
`else
    localparam int unsigned PMAX = PMAX_LIN;
`endif
    localparam int unsigned PhW = $clog2(PMAX + 1);

    logic                tick;
    logic                slot_end;
    logic [1:0]          col_nxt;
    logic [PhW-1:0]      ph_q, ph_d;
    logic [PhW-1:0]      thr_q, thr_d;
    logic [1:0]          col_q, col_d;
    logic [NUM_ROWS-1:0] snap_q, snap_d;
    logic                wrap_q, wrap_d;
    logic [NUM_ROWS-1:0] led_q, led_d;
    logic [NUM_COLS-1:0] lcol_q, lcol_d;
    logic                frame_q, frame_d;

    led_scan_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign slot_end = tick && (ph_q == PhW'(PMAX));
    assign col_nxt  = col_q + 2'd1;

    // Advance phase; at slot end move to the next column and sample inputs.
    always_comb begin
        ph_d   = ph_q;
        col_d  = col_q;
        snap_d = snap_q;
        thr_d  = thr_q;
        wrap_d = 1'b0;
        if (tick) begin
            ph_d = ph_q + PhW'(1);
        end
        if (slot_end) begin
            ph_d   = '0;
            col_d  = col_nxt;
            // Remember the 3->0 wrap so frame lines up with lcol1's new slot.
            wrap_d = (col_q == 2'd3);
            unique case (col_nxt)
                2'd0:    snap_d = leds1;
                2'd1:    snap_d = leds2;
                2'd2:    snap_d = leds3;
                default: snap_d = leds4;
            endcase
`ifdef LED_GAMMA_EN
            thr_d = gamma_lookup(leds_pwm);
`else
            thr_d = PhW'(leds_pwm);
`endif
        end
    end

    // Pin values derived from the current scan state (registered below).
    always_comb begin
        lcol_d  = '1;
        led_d   = '1;
        frame_d = wrap_q;
        if (ph_q != PhW'(PMAX)) begin
            lcol_d[col_q] = 1'b0;
            for (int n = 0; n < NUM_ROWS; n++) begin
                led_d[n] = !(snap_q[n] && (ph_q < thr_q));
            end
        end
    end

    // Scan state and output registers; reset drives every pin inactive at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q    <= '0;
            col_q   <= '0;
            snap_q  <= '0;
            thr_q   <= '0;
            wrap_q  <= 1'b0;
            led_q   <= '1;
            lcol_q  <= '1;
            frame_q <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            col_q   <= col_d;
            snap_q  <= snap_d;
            thr_q   <= thr_d;
            wrap_q  <= wrap_d;
            led_q   <= led_d;
            lcol_q  <= lcol_d;
            frame_q <= frame_d;
        end
    end

    assign {led8, led7, led6, led5, led4, led3, led2, led1} = led_q;
    assign {lcol4, lcol3, lcol2, lcol1}                     = lcol_q;
    assign frame                                            = frame_q;

endmodule
